l2_bus_interface: RTL

//  Downstream stage of the L2 cache: turns L2 miss/evict requests into system-bus transactions.
//  - Takes one request at a time: READ, WRITE (writeback), INVALIDATE or RFO, with a line address.
//  - Arbitrates for the bus, drives the address phase and samples the snoop result (NOHIT/HIT/HITM).
//  - Waits for memory completion, then returns one response carrying the snoop result to the L2 MESI logic.

---
 rtl/l2_bus_interface.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/l2_bus_interface.sv
// L2 miss/evict to system-bus transaction engine: arbitration, address phase, snoop, data wait, response.
// Optional BUS_STATS_EN adds saturating per-op and HITM event counters.
module l2_bus_interface #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned OFFSET_W    = 6,
    parameter int unsigned SNOOP_DLY   = 2,
    parameter int unsigned BACKOFF_CYC = 4,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_valid,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_hit,
    input  logic              bus_hitm,
    input  logic              bus_done,
    output logic              rsp_valid,
    output logic [1:0]        rsp_op,
    output logic [1:0]        rsp_snoop,
    output logic              rsp_err
`ifdef BUS_STATS_EN
    ,
    output logic [31:0]       stat_rd,
    output logic [31:0]       stat_wr,
    output logic [31:0]       stat_inv,
    output logic [31:0]       stat_rfo,
    output logic [31:0]       stat_hitm
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ADDR,
        S_SNOOP,
        S_BACKOFF,
        S_DATA,
        S_RESP
    } state_e;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_INV    = 2'b10;
    localparam logic [1:0] OP_RFO    = 2'b11;
    localparam logic [1:0] SNP_NOHIT = 2'b00;
    localparam logic [1:0] SNP_HIT   = 2'b01;
    localparam logic [1:0] SNP_HITM  = 2'b10;

    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + SNOOP_DLY + BACKOFF_CYC + 1);

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [RW-1:0]       retry_q, retry_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          snoop_q, snoop_d;
    logic [1:0]          rsp_op_q, rsp_op_d;
    logic [1:0]          rsp_snoop_q, rsp_snoop_d;
    logic                rsp_err_q, rsp_err_d;
    logic                finish;
    logic                fin_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            retry_q     <= '0;
            cnt_q       <= '0;
            snoop_q     <= '0;
            rsp_op_q    <= '0;
            rsp_snoop_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            retry_q     <= retry_d;
            cnt_q       <= cnt_d;
            snoop_q     <= snoop_d;
            rsp_op_q    <= rsp_op_d;
            rsp_snoop_q <= rsp_snoop_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // One shared counter times SNOOP, BACKOFF and DATA; it restarts on every state change.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        retry_d     = retry_q;
        cnt_d       = cnt_q + 1'b1;
        snoop_d     = snoop_q;
        rsp_op_d    = rsp_op_q;
        rsp_snoop_d = rsp_snoop_q;
        rsp_err_d   = rsp_err_q;
        finish      = 1'b0;
        fin_err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = (req_addr >> OFFSET_W) << OFFSET_W;
                    retry_d = '0;
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                cnt_d = '0;
                if (bus_gnt) state_d = S_ADDR;
            end
            S_ADDR: begin
                cnt_d   = '0;
                state_d = S_SNOOP;
            end
            S_SNOOP: begin
                if (cnt_q == CW'(SNOOP_DLY - 1)) begin
                    cnt_d   = '0;
                    snoop_d = bus_hitm ? SNP_HITM : (bus_hit ? SNP_HIT : SNP_NOHIT);
                    if (bus_hitm && (op_q == OP_READ || op_q == OP_RFO)) begin
                        if (retry_q == RW'(MAX_RETRY)) begin
                            finish  = 1'b1;
                            fin_err = 1'b1;
                        end else begin
                            retry_d = retry_q + 1'b1;
                            state_d = S_BACKOFF;
                        end
                    end else if (op_q == OP_INV) begin
                        finish = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_BACKOFF: begin
                if (cnt_q == CW'(BACKOFF_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_ARB;
                end
            end
            S_DATA: begin
                if (bus_done) begin
                    finish = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (finish) begin
            state_d     = S_RESP;
            rsp_op_d    = op_q;
            rsp_snoop_d = snoop_d;
            rsp_err_d   = fin_err;
        end
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        bus_req   = (state_q == S_ARB) || (state_q == S_ADDR);
        bus_valid = (state_q == S_ADDR);
        bus_op    = (state_q == S_ADDR) ? op_q : '0;
        bus_addr  = (state_q == S_ADDR) ? addr_q : '0;
        rsp_valid = (state_q == S_RESP);
        rsp_op    = rsp_op_q;
        rsp_snoop = rsp_snoop_q;
        rsp_err   = rsp_err_q;
    end

`ifdef BUS_STATS_EN
    logic hitm_sample;
    assign hitm_sample = (state_q == S_SNOOP) && (cnt_q == CW'(SNOOP_DLY - 1)) && bus_hitm;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_rd   <= '0;
            stat_wr   <= '0;
            stat_inv  <= '0;
            stat_rfo  <= '0;
            stat_hitm <= '0;
        end else begin
            if (state_q == S_ADDR) begin
                case (op_q)
                    OP_READ:  stat_rd  <= sat_inc(stat_rd);
                    OP_WRITE: stat_wr  <= sat_inc(stat_wr);
                    OP_INV:   stat_inv <= sat_inc(stat_inv);
                    default:  stat_rfo <= sat_inc(stat_rfo);
                endcase
            end
            if (hitm_sample) stat_hitm <= sat_inc(stat_hitm);
        end
    end
`endif

endmodule
